muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported and verified.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 opa  input  32  rs1 operand (ALU-a side buffer output).
REQ-007 opb  input  32  rs2 operand (rs2 buffer output).
REQ-008 flush  input  1  synchronous abort from hazard/branch logic.
REQ-009 busy  output  1  high whenever state is not IDLE; drives the pipeline stall.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  32  registered result, held until the next completion.
REQ-012 illegal  output  1  pulses with done when the op is unsupported in this build.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-014 In IDLE with start=1 and flush=0, the edge (E0) SHALL capture op, opa, opb and enter CALC with iteration counter = 0; otherwise the FSM stays in IDLE.
REQ-015 Start SHALL be ignored in CALC and DONE; DONE SHALL always return to IDLE after one cycle.
REQ-016 Multiply: 32 shift-add iterations on magnitudes (signedness per op); 64-bit product sign-corrected; MUL returns bits[31:0], MULH/MULHSU/MULHU return bits[63:32].
REQ-017 Divide: 32 restoring iterations on magnitudes; quotient sign = sign(a) XOR sign(b) for DIV; remainder takes sign of dividend for REM.
REQ-018 Normal ops SHALL leave CALC after exactly 32 CALC edges (E1..E32); done is high in the cycle following E32.
REQ-019 Divide by zero SHALL bypass CALC (IDLE -> DONE at E0): quotient 0xFFFFFFFF, remainder = opa.
REQ-020 Signed overflow (DIV/REM, opa=0x80000000, opb=0xFFFFFFFF) SHALL bypass CALC: quotient 0x80000000, remainder 0.
REQ-021 result SHALL update only on entry to DONE; flushed operations never modify it.
REQ-022 flush=1 in CALC or DONE SHALL force IDLE at the next edge; no done pulse follows; flush in DONE does not suppress the pulse already visible in that cycle.
REQ-023 flush=1 and start=1 together in IDLE: flush wins; the request is not accepted.
REQ-024 The iteration counter SHALL be 6 bits, saturate-free, and be cleared on every acceptance.

Reset
REQ-025 rst SHALL immediately force state IDLE, counter 0, result 0x00000000, busy 0, done 0, illegal 0, and internal operand/partial registers 0.
REQ-026 rst asserted mid-operation SHALL abandon it; no done pulse after release.

Configuration
REQ-027 Macro MULDIV_DIV_EN: when defined, divide ops behave per REQ-017..REQ-020 and illegal stays 0.
REQ-028 Without MULDIV_DIV_EN the divider datapath SHALL be omitted; op[2]=1 goes IDLE -> DONE at E0 with result 0x00000000 and illegal=1 during the done cycle; multiply is unaffected.

Verification
REQ-029 MUL opa=7, opb=0xFFFFFFFD -> result 0xFFFFFFEB, done in the cycle after E32, busy high E0..E32.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV opa=0xFFFFFFF9 (-7), opb=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF after 1 cycle; REMU 100/0 -> 0x00000064.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done the cycle after E0; REM -> 0x00000000.
REQ-033 Start MUL, flush at CALC cycle 10 -> busy low next cycle, no done, result retains prior value; start+flush together in IDLE -> busy stays 0.
REQ-034 rst pulsed mid-CALC -> all outputs 0 immediately; new MUL 3x5 after release -> 0x0000000F; without MULDIV_DIV_EN, DIVU 10/2 -> result 0, illegal=1 with done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Multiply runs 32 shift-add steps on operand magnitudes and sign-corrects the
// 64-bit product. Divide runs 32 restoring steps on magnitudes. Divide by zero
// and signed overflow complete without iterating.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it, any
// op with op[2]=1 completes immediately with result 0 and illegal=1.
//
// Handshake: start is sampled only while busy=0. With flush=0 the request is
// accepted at that edge and busy rises. Completion is signalled by a one-cycle
// done pulse with result (and illegal) valid in that same cycle. flush aborts
// an accepted operation at the next edge without a done pulse. flush also
// blocks acceptance in IDLE.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op       request and RV32M funct3 opcode
//   opa, opb        rs1 / rs2 operands
//   flush           synchronous abort
//   busy            state != IDLE (pipeline stall)
//   done            one-cycle completion pulse
//   result          registered result, held until the next completion
//   illegal         pulses with done for ops unsupported in this build
//   state_dbg       current FSM state (IDLE=0, CALC=1, DONE=2)
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;      // funct3[1:0] of the accepted op
  logic [XLEN-1:0] mcand_q, mcand_d; // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier-then-product low / dividend-then-quotient
  logic            neg_q, neg_d;     // final result must be negated
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
`ifdef MULDIV_DIV_EN
  logic            div_q, div_d;     // accepted op is a divide
`endif

  // Operand signedness and magnitudes of the incoming request.
  logic            a_signed_in, b_signed_in;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  always_comb begin
    if (op[2]) begin
      a_signed_in = ~op[0];
      b_signed_in = ~op[0];
    end else begin
      a_signed_in = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
      b_signed_in = (op[1:0] == 2'b01);
    end
    a_neg_in = a_signed_in & opa[XLEN-1];
    b_neg_in = b_signed_in & opb[XLEN-1];
    a_mag_in = a_neg_in ? -opa : opa;
    b_mag_in = b_neg_in ? -opb : opb;
  end

  // One shift-add multiply step: add the multiplicand to the high half when
  // the current multiplier bit is set, then shift {carry, hi, lo} right.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    prod_fix = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
    mul_res  = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  // One restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The remainder stays
  // below the divisor, so the shifted value needs only one extra bit.
  logic [XLEN:0]   rem_sh;
  logic            div_fit;
  logic [XLEN-1:0] div_hi_n, div_lo_n;
  logic [XLEN-1:0] div_res;

  always_comb begin
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    div_fit  = rem_sh >= {1'b0, mcand_q};
    div_hi_n = div_fit ? (rem_sh[XLEN-1:0] - mcand_q) : rem_sh[XLEN-1:0];
    div_lo_n = {lo_q[XLEN-2:0], div_fit};
    if (op_q[1]) div_res = neg_q ? -div_hi_n : div_hi_n;
    else         div_res = neg_q ? -div_lo_n : div_lo_n;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = op[1:0];
          cnt_d = '0;
          if (op[2]) begin
`ifdef MULDIV_DIV_EN
            div_d = 1'b1;
            if (opb == '0) begin
              state_d  = DONE;
              result_d = op[1] ? opa : '1;
            end else if (!op[0] && opa == {1'b1, {(XLEN-1){1'b0}}} && opb == '1) begin
              state_d  = DONE;
              result_d = op[1] ? '0 : opa;
            end else begin
              state_d = CALC;
              mcand_d = b_mag_in;
              hi_d    = '0;
              lo_d    = a_mag_in;
              // Remainder follows the dividend's sign; quotient the XOR.
              neg_d   = op[1] ? a_neg_in : (a_neg_in ^ b_neg_in);
            end
`else
            state_d   = DONE;
            result_d  = '0;
            illegal_d = 1'b1;
`endif
          end else begin
`ifdef MULDIV_DIV_EN
            div_d   = 1'b0;
`endif
            state_d = CALC;
            mcand_d = a_mag_in;
            hi_d    = '0;
            lo_d    = b_mag_in;
            neg_d   = a_neg_in ^ b_neg_in;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
          if (div_q) begin
            hi_d = div_hi_n;
            lo_d = div_lo_n;
          end else begin
            hi_d = mul_hi_n;
            lo_d = mul_lo_n;
          end
`else
          hi_d = mul_hi_n;
          lo_d = mul_lo_n;
`endif
          // Counter value 31 marks the 32nd step; the result is latched
          // from this step's combinational output on the way into DONE.
          if (cnt_q == 6'd31) begin
            state_d = DONE;
`ifdef MULDIV_DIV_EN
            result_d = div_q ? div_res : mul_res;
`else
            result_d = mul_res;
`endif
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
      div_q     <= div_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed plus randomized bench for muldiv_unit.
// Expected results come from a 64-bit arithmetic model of the RV32M rules.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        flush;
  logic        busy, done, illegal;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result;
  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic [63:0]        ua64;
    logic [63:0]        ub64;
    logic [63:0]        p;
    int                 sa, sb;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    sa = a;
    sb = b;
    p = '0;
    ref_result = '0;
    case (o)
      3'd0: begin p = ua64 * ub64; ref_result = p[31:0]; end
      3'd1: begin p = sa64 * sb64; ref_result = p[63:32]; end
      3'd2: begin p = sa64 * $signed(ub64); ref_result = p[63:32]; end
      3'd3: begin p = ua64 * ub64; ref_result = p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else ref_result = 32'(sa / sb);
      end
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
        else ref_result = 32'(sa % sb);
      end
      3'd7: ref_result = (b == 0) ? a : a % b;
`endif
      default: ref_result = 32'd0;
    endcase
  endfunction

  // Edges after the accepting edge until done is visible.
  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 32;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 0;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
`else
    if (a == b) return 0;  // keeps both operands referenced; same answer either way
    return 0;
`endif
  endfunction

  function automatic logic ref_illegal(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
    if (o[2]) return 1'b0;
    return 1'b0;
`else
    return o[2];
`endif
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int   lat;
    logic busy_ok;
    logic [31:0] exp_r;
    exp_q.push_back(ref_result(o, a, b));
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    exp_r = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(ref_latency(o, a, b)));
    check({tag, "_result"}, {32'd0, result}, {32'd0, exp_r});
    check({tag, "_illegal"}, {63'd0, illegal}, {63'd0, ref_illegal(o)});
    check({tag, "_busy"}, {63'd0, busy_ok & busy}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {62'd0, done, busy}, 64'd0);
    last_result = exp_r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic seen_done;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; flush = 1'b0;
    last_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, busy, done, illegal, state_dbg, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_7_neg3",     3'd0, 32'd7,          32'hFFFF_FFFD);
    check("mul_7_neg3_value", {32'd0, last_result}, 64'h0000_0000_FFFF_FFEB);
    run_op("mulhu_ff",       3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_ff",        3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_ff_2",    3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_0",     3'd5, 32'd100,        32'd0);
    run_op("remu_100_0",     3'd7, 32'd100,        32'd0);
    run_op("div_ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_10_2",      3'd5, 32'd10,         32'd2);

    // Flush in the middle of CALC: no done, result untouched.
    run_op("mul_before_flush", 3'd0, 32'd1234, 32'd5678);
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd123; opb = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_idle", {62'd0, busy, done}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("flush_calc_no_done", {63'd0, seen_done}, 64'd0);
    check("flush_calc_result", {32'd0, result}, {32'd0, last_result});

    // start and flush together in IDLE: not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", {62'd0, busy, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("start_flush_result", {32'd0, result}, {32'd0, last_result});

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd77; opb = 32'd88;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_calc", {27'd0, busy, done, illegal, state_dbg, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("rst_no_done", {63'd0, seen_done}, 64'd0);
    run_op("mul_3_5", 3'd0, 32'd3, 32'd5);
    check("mul_3_5_value", {32'd0, last_result}, 64'h0000_0000_0000_000F);

    // Randomized ops, biased toward the division corner cases.
    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      n    = $urandom_range(0, 9);
      if (n == 0) r_b = 32'd0;
      else if (n == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      else if (n == 2) r_b = 32'($urandom_range(1, 15));
      else if (n == 3) r_a = 32'($urandom_range(0, 255));
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
